// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//   Column-scanning controller for a 4-row x 3-column matrix keypad.
//   One column is driven at a time for SCAN_DIV cycles. On the last cycle of
//   each column's dwell, the four row lines are captured into a 12-bit sweep
//   snapshot. At the end of each sweep (the COL2 sample edge), the snapshot is
//   compared with the previous one. Once DEBOUNCE identical sweeps have been
//   seen, the snapshot is published on key_data.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   key_row   in   [3:0]  row sense lines, active-high, sampled synchronously
//   key_col   out  [2:0]  registered one-hot column drive
//   key_data  out  [11:0] debounced key map, bit (row*3 + col)
//
// Handshake: none. key_data is a level output that changes only on
// end-of-sweep edges and holds its value between them.
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 1,
    parameter int DEBOUNCE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic [11:0] key_data
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_t;

    col_state_t    state, state_next;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_last;
    logic          sweep_end;
    logic [2:0]    col_next;
    logic [11:0]   snapshot, snap_next;
    logic [11:0]   prev_snapshot;
    logic [SW-1:0] stable_cnt, stable_next;
    logic          snap_match;

    assign dwell_last = (dwell_cnt == DW'(SCAN_DIV - 1));
    assign sweep_end  = dwell_last && (state == COL2);

    // Column FSM: next state and the matching one-hot drive. key_col is
    // registered together with the state, so it never glitches and is one-hot
    // straight out of reset.
    always_comb begin
        state_next = state;
        col_next   = key_col;
        if (dwell_last) begin
            case (state)
                COL0:    state_next = COL1;
                COL1:    state_next = COL2;
                default: state_next = COL0;
            endcase
            case (state_next)
                COL1:    col_next = 3'b010;
                COL2:    col_next = 3'b100;
                default: col_next = 3'b001;
            endcase
        end
    end

    // Snapshot with the current column's rows merged in. At sweep end this
    // value is the completed snapshot, which includes the COL2 sample taken on
    // this same edge.
    always_comb begin
        snap_next = snapshot;
        for (int r = 0; r < 4; r++) begin
            case (state)
                COL0:    snap_next[r*3 + 0] = key_row[r];
                COL1:    snap_next[r*3 + 1] = key_row[r];
                default: snap_next[r*3 + 2] = key_row[r];
            endcase
        end
    end

    assign snap_match = (snap_next == prev_snapshot);

    // The stable counter saturates at DEBOUNCE. A new snapshot restarts the
    // count at 1 because that sweep is the first sighting of the value.
    always_comb begin
        stable_next = SW'(1);
        if (snap_match) begin
            if (stable_cnt == SW'(DEBOUNCE))
                stable_next = stable_cnt;
            else
                stable_next = stable_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= COL0;
            key_col       <= 3'b001;
            dwell_cnt     <= '0;
            snapshot      <= '0;
            prev_snapshot <= '0;
            stable_cnt    <= '0;
            key_data      <= '0;
        end else begin
            state   <= state_next;
            key_col <= col_next;
            if (dwell_last) begin
                dwell_cnt <= '0;
                snapshot  <= snap_next;
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
            if (sweep_end) begin
                stable_cnt <= stable_next;
                if (!snap_match)
                    prev_snapshot <= snap_next;
                if (stable_next == SW'(DEBOUNCE))
                    key_data <= snap_next;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//   Directed bench for keypad_scan_ctrl with default parameters
//   (SCAN_DIV=1, DEBOUNCE=2). A small keypad model turns a 12-bit "pressed"
//   map into row levels for whichever column is driven. Expected key maps are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key_data;

    logic [11:0] pressed;
    logic        bounce_en;
    logic [3:0]  bounce_row;
    logic [3:0]  model_row;

    int checks;
    int failures;

    keypad_scan_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_data (key_data)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad model ----------------
    always_comb begin
        model_row = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            case (key_col)
                3'b001:  model_row[r] = pressed[r*3 + 0];
                3'b010:  model_row[r] = pressed[r*3 + 1];
                3'b100:  model_row[r] = pressed[r*3 + 2];
                default: model_row[r] = 1'b0;
            endcase
        end
    end

    assign key_row = bounce_en ? bounce_row : model_row;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Align to a negedge where COL0 is driven, so the next posedge starts a
    // fresh sweep. Bounded wait.
    task automatic align_col0();
        int k;
        k = 0;
        @(negedge clk);
        while (key_col != 3'b001 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("align_col0", {9'd0, key_col}, 12'h001);
    endtask

    // Press a key map at a sweep boundary. With DEBOUNCE=2 the first sweep
    // only records the new value; the second sweep publishes it, so key_data
    // is still the old value after 5 edges and the new one after 6.
    task automatic apply_keys(input string tag, input logic [11:0] map,
                              input logic [11:0] old_exp, input logic [11:0] new_exp);
        align_col0();
        pressed = map;
        step(5);
        check({tag, "_hold"}, key_data, old_exp);
        step(1);
        check({tag, "_new"}, key_data, new_exp);
        step(3);
        check({tag, "_stay"}, key_data, new_exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        pressed    = 12'h000;
        bounce_en  = 1'b0;
        bounce_row = 4'b0000;

        // 1. Reset and column rotation
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_col", {9'd0, key_col}, 12'h001);
        check("rst_data", key_data, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        check("rot_col1", {9'd0, key_col}, 12'h002);
        step(1);
        check("rot_col2", {9'd0, key_col}, 12'h004);
        step(1);
        check("rot_col0", {9'd0, key_col}, 12'h001);
        step(1);
        check("rot_col1b", {9'd0, key_col}, 12'h002);
        step(6);
        check("idle_data", key_data, 12'h000);

        // 2. Single key (row 0, col 1) then release
        apply_keys("single", 12'h002, 12'h000, 12'h002);
        apply_keys("release", 12'h000, 12'h002, 12'h000);

        // 3. Row mapping
        apply_keys("r3c2", 12'h800, 12'h000, 12'h800);
        apply_keys("r1c0", 12'h008, 12'h800, 12'h008);
        apply_keys("r2c0", 12'h040, 12'h008, 12'h040);

        // 4. Whole rows, and all keys together
        apply_keys("row1", 12'h038, 12'h040, 12'h038);
        apply_keys("row2", 12'h1C0, 12'h038, 12'h1C0);
        apply_keys("multi", 12'hA5C, 12'h1C0, 12'hA5C);
        apply_keys("clear", 12'h000, 12'hA5C, 12'h000);

        // 5. Bounce: row 0 toggles every clock; odd sweep length means
        // consecutive snapshots alternate and never match.
        align_col0();
        bounce_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bounce_row = bounce_row ^ 4'b0001;
            @(negedge clk);
            if (i % 6 == 5) check("bounce_hold", key_data, 12'h000);
        end
        bounce_en  = 1'b0;
        bounce_row = 4'b0000;
        step(9);
        check("bounce_after", key_data, 12'h000);

        // 6. Mid-sweep asynchronous reset with a key held
        apply_keys("pre_rst", 12'h010, 12'h000, 12'h010);
        @(negedge clk);
        while (key_col != 3'b010) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_col", {9'd0, key_col}, 12'h001);
        check("async_data", key_data, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        // After release prev_snapshot is 0, so the first sweep records the
        // key and the second publishes it.
        step(5);
        check("post_rst_hold", key_data, 12'h000);
        step(1);
        check("post_rst_new", key_data, 12'h010);
        check("post_rst_col", {9'd0, key_col}, 12'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Column-scanning controller for a 4-row x 3-column matrix keypad (12 keys).
- Drives one column at a time, samples the four row lines and assembles a 12-bit snapshot per full sweep.
- Debounces the snapshot and presents it as a 12-bit key map (one bit per key).
- Sits between the keypad pins and the key-decode/user logic.

Parameters:
SCAN_DIV, 1, clock cycles each column stays driven (dwell); legal range >= 1.
DEBOUNCE, 2, number of consecutive identical sweep snapshots required before key_data updates; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (rst=0 resets).
key_row  input  4  row sense lines, active-high (1 = key in the driven column pressed), sampled synchronously.
key_col  output  3  column drive, one-hot active-high.
key_data  output  12  debounced key map; bit (row*3 + col) = 1 when that key is pressed.

Behaviour:
- Reset (rst=0, asynchronous):
  - key_col=3'b001, key_data=12'h000.
  - Dwell counter, column index, snapshot, previous snapshot and stable counter all cleared.
- Column FSM states: COL0 (key_col=001) -> COL1 (010) -> COL2 (100) -> COL0.
  - Each state is held exactly SCAN_DIV cycles, so one sweep = 3*SCAN_DIV cycles.
  - key_col is registered and always exactly one-hot, including immediately after reset.
- Sampling:
  - On the last cycle of a column's dwell, key_row[r] is written into snapshot bit r*3+c, where c = current column index.
  - Row 0 maps to bits 0..2, row 3 maps to bits 9..11.
- End of sweep (the clock edge that samples COL2):
  - If the completed snapshot equals the previous snapshot, stable_cnt increments, saturating at DEBOUNCE.
  - Otherwise prev_snapshot <= snapshot and stable_cnt <= 1.
  - When stable_cnt reaches DEBOUNCE, key_data <= that snapshot.
- Timing and latency:
  - key_data changes only at end-of-sweep edges; it is stable between them.
  - With DEBOUNCE=1, key_data follows every sweep.
  - Latency from a stable row change to a key_data update is at most (DEBOUNCE+1) sweeps.
- Key combinations:
  - Multiple simultaneous keys are all reported; no priority or encoding.
  - Ghosting is not suppressed.
- Row bounce: any row change mid-sweep corrupts only that sweep's snapshot, which then fails the equality check; key_data keeps its last debounced value.
- Reset mid-sweep: partial snapshot discarded and scanning restarts at COL0 on release.
- Release: an all-zero snapshot stable for DEBOUNCE sweeps clears key_data to 12'h000.
- No combinational path from key_row to any output.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then release -> key_col=001 and key_data=000 during reset; key_col then rotates 001,010,100 every SCAN_DIV cycles.
2. Single key, defaults: key_row=4'b0001 held only while key_col=010 (other columns 0) -> after 2 identical sweeps key_data=12'h002; after release and 2 sweeps key_data=12'h000.
3. Row mapping: with key_col=100, hold key_row=4'b1000 (all other columns 0) -> key_data=12'h800. Repeat for rows 1 and 2 in column 0 -> 12'h008 and 12'h040.
4. Whole row: key_row=4'b0010 held constantly for all columns -> key_data=12'h038. Then 4'b0100 constantly -> 12'h1C0.
5. Bounce: toggle key_row between 0000 and 0001 every clock (SCAN_DIV=1) -> snapshots never match twice in a row; key_data stays at its prior value (12'h000).
6. Mid-sweep reset: assert rst=0 while key_col=010 with a key pressed -> key_col=001 and key_data=000 immediately (asynchronous); scan restarts cleanly after release.
